// File: rtl/conv_mac_acc.sv
// conv_mac_acc: multi-tap signed x unsigned MAC with a registered adder tree,
// per-group channel accumulation, output saturation and optional ReLU.
module conv_mac_acc #(
    parameter int NUM    = 49,
    parameter int WEI_W  = 16,
    parameter int IMA_W  = 8,
    parameter int FRAC   = 8,
    parameter int OUT_W  = 16,
    parameter int MAX_CH = 64,
    parameter int RELU   = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   in_first,
    input  logic                   in_last,
    input  logic [NUM*WEI_W-1:0]   wei,
    input  logic [NUM*IMA_W-1:0]   ima,
    input  logic [WEI_W-1:0]       bias,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_valid,
    output logic                   out_sat,
    output logic                   err
);
    localparam int N1        = NUM + 1;
    localparam int TREE      = $clog2(N1);
    localparam int SW        = WEI_W + IMA_W + TREE;
    localparam int ACC_W     = SW + $clog2(MAX_CH);
    localparam int P         = TREE + 1;
    // pixels are integers, so products carry the weight's fraction and need no bias shift
    localparam int PROD_FRAC = FRAC;
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

    typedef enum logic {IDLE, OPEN} state_t;

    state_t                   state_q, state_d;
    logic                     keep, err_q, err_d;
    logic [P:0]               v_q, v_d, f_q, f_d, l_q, l_d;
    logic [NUM*WEI_W-1:0]     wei_q, wei_d;
    logic [NUM*IMA_W-1:0]     ima_q, ima_d;
    logic [WEI_W-1:0]         bias_q, bias_d;
    logic signed [SW-1:0]     tree_q [TREE+1][N1+1];
    logic signed [SW-1:0]     tree_d [TREE+1][N1+1];
    logic signed [ACC_W-1:0]  acc_q, acc_d, sum;
    logic                     accl_q, accl_d, hi, lo;
    logic [OUT_W-1:0]         clamped, out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d, out_sat_q, out_sat_d;

    always_comb begin
        state_d = state_q;
        keep    = 1'b0;
        err_d   = 1'b0;
        if (in_valid) begin
            keep    = in_first || state_q == OPEN;
            err_d   = in_first ? state_q == OPEN : state_q == IDLE;
            state_d = (keep && !in_last) ? OPEN : IDLE;
        end
        v_d    = {v_q[P-1:0], keep};
        f_d    = {f_q[P-1:0], in_first};
        l_d    = {l_q[P-1:0], in_last};
        wei_d  = wei;
        ima_d  = ima;
        bias_d = bias;
    end

    // unused tree slots stay zero, so an odd leftover simply pairs with zero
    always_comb begin
        tree_d = '{default: '0};
        for (int k = 0; k < NUM; k++)
            tree_d[0][k] = SW'($signed(wei_q[k*WEI_W +: WEI_W])) * SW'($signed({1'b0, ima_q[k*IMA_W +: IMA_W]}));
        tree_d[0][NUM] = f_q[0] ? SW'($signed(bias_q)) <<< (PROD_FRAC - FRAC) : '0;
        for (int l = 1; l <= TREE; l++)
            for (int i = 0; i < (N1 + 1) / 2; i++)
                tree_d[l][i] = tree_q[l-1][2*i] + tree_q[l-1][2*i+1];
    end

    always_comb begin
        sum         = ACC_W'(tree_q[TREE][0]);
        acc_d       = v_q[P] ? (f_q[P] ? sum : acc_q + sum) : acc_q;
        accl_d      = v_q[P] && l_q[P];
        hi          = acc_q > MAXV;
        lo          = acc_q < MINV;
        clamped     = hi ? MAXV[OUT_W-1:0] : lo ? MINV[OUT_W-1:0] : acc_q[OUT_W-1:0];
        out_valid_d = accl_q;
        out_sat_d   = accl_q && (hi || lo);
        out_data_d  = !accl_q ? out_data_q : (RELU != 0 && clamped[OUT_W-1]) ? '0 : clamped;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            err_q       <= 1'b0;
            v_q         <= '0;
            f_q         <= '0;
            l_q         <= '0;
            wei_q       <= '0;
            ima_q       <= '0;
            bias_q      <= '0;
            tree_q      <= '{default: '0};
            acc_q       <= '0;
            accl_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            v_q         <= v_d;
            f_q         <= f_d;
            l_q         <= l_d;
            wei_q       <= wei_d;
            ima_q       <= ima_d;
            bias_q      <= bias_d;
            tree_q      <= tree_d;
            acc_q       <= acc_d;
            accl_q      <= accl_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sat   = out_sat_q;
    assign err       = err_q;
endmodule

// File: tb/tb_conv_mac_acc.sv
// tb_conv_mac_acc: directed vectors for conv_mac_acc with defaults, plus a RELU=1
// twin sharing the same inputs.
module tb_conv_mac_acc;
    logic         clk = 0, rst_n = 0, in_valid = 0, in_first = 0, in_last = 0;
    logic [783:0] wei = '0;
    logic [391:0] ima = '0;
    logic [15:0]  bias = '0;
    logic [15:0]  out_data, out_data_r;
    logic         out_valid, out_valid_r, out_sat, out_sat_r, err, err_r;
    int           ncmp = 0, nbad = 0, nv = 0, ne = 0;

    typedef struct {
        logic [15:0] w;
        logic [7:0]  i;
        logic [15:0] b;
        logic [15:0] d;
        logic        s;
        logic [15:0] rd;
        logic        rs;
    } vec_t;

    vec_t tab [10];

    always #5 clk = ~clk;

    conv_mac_acc dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .wei(wei), .ima(ima), .bias(bias),
        .out_data(out_data), .out_valid(out_valid), .out_sat(out_sat), .err(err)
    );

    conv_mac_acc #(.RELU(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .wei(wei), .ima(ima), .bias(bias),
        .out_data(out_data_r), .out_valid(out_valid_r), .out_sat(out_sat_r), .err(err_r)
    );

    always @(negedge clk) begin
        if (out_valid) nv++;
        if (err) ne++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // call at a negedge; the beat is accepted at the following posedge
    task automatic beat(input logic [15:0] w, input logic [7:0] i, input logic [15:0] b,
                        input logic f, input logic l);
        for (int k = 0; k < 49; k++) begin
            wei[k*16 +: 16] = w;
            ima[k*8 +: 8]   = i;
        end
        bias     = b;
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_out(output int n);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n, nv0, ne0, got;
        logic [15:0] b2b [4];
        b2b = '{16'h0031, 16'h0062, 16'h0093, 16'h00C4};
        tab = '{
            '{16'h0100, 8'h01, 16'h0000, 16'h3100, 1'b0, 16'h3100, 1'b0},
            '{16'h7FFF, 8'hFF, 16'h7FFF, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1},
            '{16'h8000, 8'hFF, 16'h0000, 16'h8000, 1'b1, 16'h0000, 1'b1},
            '{16'hFF00, 8'h01, 16'h0000, 16'hCF00, 1'b0, 16'h0000, 1'b0},
            '{16'h0001, 8'h03, 16'hFFF0, 16'h0083, 1'b0, 16'h0083, 1'b0},
            '{16'hFFFF, 8'hC8, 16'h0064, 16'hDA1C, 1'b0, 16'h0000, 1'b0},
            '{16'h0002, 8'hFF, 16'h0000, 16'h619E, 1'b0, 16'h619E, 1'b0},
            '{16'h0000, 8'h00, 16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, 1'b0},
            '{16'h0001, 8'h01, 16'h7FFF, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1},
            '{16'h0000, 8'h00, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0}
        };

        repeat (2) @(negedge clk);
        chk("rst_data", out_data, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_sat", out_sat, 0);
        chk("rst_err", err, 0);
        rst_n = 1;
        @(negedge clk);

        foreach (tab[v]) begin
            beat(tab[v].w, tab[v].i, tab[v].b, 1'b1, 1'b1);
            wait_out(n);
            chk($sformatf("v%0d_lat", v), n, 9);
            chk($sformatf("v%0d_data", v), out_data, tab[v].d);
            chk($sformatf("v%0d_sat", v), out_sat, tab[v].s);
            chk($sformatf("v%0d_rvalid", v), out_valid_r, 1);
            chk($sformatf("v%0d_rdata", v), out_data_r, tab[v].rd);
            chk($sformatf("v%0d_rsat", v), out_sat_r, tab[v].rs);
            @(negedge clk);
            chk($sformatf("v%0d_pulse", v), out_valid, 0);
            chk($sformatf("v%0d_hold", v), out_data, tab[v].d);
        end

        nv0 = nv;
        beat(16'h0080, 8'h01, 16'h0100, 1'b1, 1'b0);
        beat(16'h0080, 8'h01, 16'h7777, 1'b0, 1'b0);
        beat(16'h0080, 8'h01, 16'h7777, 1'b0, 1'b1);
        wait_out(n);
        chk("grp3_lat", n, 9);
        chk("grp3_data", out_data, 16'h4A80);
        repeat (3) @(negedge clk);
        @(posedge clk);
        chk("grp3_count", nv - nv0, 1);
        @(negedge clk);

        nv0 = nv;
        ne0 = ne;
        beat(16'h0100, 8'h01, 16'h0000, 1'b0, 1'b1);
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        @(posedge clk);
        chk("idle_err", ne - ne0, 1);
        chk("idle_noout", nv - nv0, 0);
        @(negedge clk);

        nv0 = nv;
        ne0 = ne;
        beat(16'h0100, 8'h01, 16'h0000, 1'b1, 1'b0);
        beat(16'h0080, 8'h01, 16'h0100, 1'b1, 1'b0);
        beat(16'h0080, 8'h01, 16'h0000, 1'b0, 1'b1);
        wait_out(n);
        chk("ff_lat", n, 9);
        chk("ff_data", out_data, 16'h3200);
        repeat (3) @(negedge clk);
        @(posedge clk);
        chk("ff_err", ne - ne0, 1);
        chk("ff_count", nv - nv0, 1);
        @(negedge clk);

        for (int k = 0; k < 4; k++) beat(16'(k + 1), 8'h01, 16'h0000, 1'b1, 1'b1);
        in_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) begin
                if (got < 4) chk($sformatf("b2b%0d", got), out_data, b2b[got]);
                got++;
            end
        end
        chk("b2b_count", got, 4);

        for (int k = 0; k < 4; k++) beat(16'h0100, 8'h01, 16'h0000, 1'b1, 1'b1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_data", out_data, 0);
        @(negedge clk);
        @(negedge clk);
        chk("arst_valid", out_valid, 0);
        chk("arst_sat", out_sat, 0);
        chk("arst_err", err, 0);
        chk("arst_data2", out_data, 0);
        rst_n = 1'b1;
        nv0 = nv;
        repeat (15) @(negedge clk);
        @(posedge clk);
        chk("arst_noout", nv - nv0, 0);
        @(negedge clk);
        beat(16'h0100, 8'h01, 16'h0000, 1'b1, 1'b1);
        wait_out(n);
        chk("arst_lat", n, 9);
        chk("arst_next", out_data, 16'h3100);
        chk("arst_nsat", out_sat, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule

// File: doc/conv_mac_acc.md
CONV_MAC_ACC -- requirements
Module: conv_mac_acc

Interface
REQ-001 SHALL provide parameter NUM, default 49: number of multiply taps per beat (kernel size squared).
REQ-002 SHALL provide parameter WEI_W, default 16: signed weight and bias width, two's complement.
REQ-003 SHALL provide parameter IMA_W, default 8: unsigned pixel width.
REQ-004 SHALL provide parameter FRAC, default 8: fractional bits of the weight, bias and output formats.
REQ-005 SHALL provide parameter OUT_W, default 16: signed output width.
REQ-006 SHALL provide parameter MAX_CH, default 64: maximum number of beats per accumulation group for which the internal width is guaranteed.
REQ-007 SHALL provide parameter RELU, default 0: when 1, negative results are clamped to 0.
REQ-008 SHALL provide the port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-009 SHALL provide the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL provide the port in_valid, input, 1 bit: a beat is accepted on every rising edge where in_valid=1; there is no backpressure.
REQ-011 SHALL provide the port in_first, input, 1 bit: marks the first beat (first channel) of a group.
REQ-012 SHALL provide the port in_last, input, 1 bit: marks the last beat of a group.
REQ-013 SHALL provide the port wei, input, NUM*WEI_W bits: packed weights, tap k at [k*WEI_W +: WEI_W].
REQ-014 SHALL provide the port ima, input, NUM*IMA_W bits: packed pixels, tap k at [k*IMA_W +: IMA_W].
REQ-015 SHALL provide the port bias, input, WEI_W bits: signed bias, sampled on in_first beats only.
REQ-016 SHALL provide the port out_data, output, OUT_W bits: saturated signed result with FRAC fractional bits.
REQ-017 SHALL provide the port out_valid, output, 1 bit: one-cycle pulse qualifying out_data.
REQ-018 SHALL provide the port out_sat, output, 1 bit: pulses together with out_valid when the result was clamped by saturation.
REQ-019 SHALL provide the port err, output, 1 bit: one-cycle pulse on a framing error.

Function
REQ-020 SHALL form each product as signed wei[k] times zero-extended ima[k], exact, with FRAC fractional bits.
REQ-021 SHALL register the products (stage 1), then sum NUM products plus bias (on first beats; 0 on other beats) in a registered pairwise tree of TREE=clog2(NUM+1) stages, with one bit of growth per stage and odd leftovers passed through registered.
REQ-022 SHALL keep an accumulator of ACC_W = WEI_W+IMA_W+clog2(NUM+1)+clog2(MAX_CH) bits; a first beat loads the tree sum into it, and any other beat adds the tree sum to it, with no loss of bits.
REQ-023 SHALL, on a last beat, clamp the accumulator to [-2^(OUT_W-1), 2^(OUT_W-1)-1], then apply RELU if enabled, and register the result into out_data.
REQ-024 SHALL assert out_valid exactly LAT = TREE+3 cycles after the edge accepting the in_last beat; with defaults, LAT=9.
REQ-025 SHALL accept one beat per cycle sustained; back-to-back groups, including single-beat groups, SHALL produce one out_valid per group, in order.
REQ-026 SHALL hold out_data at its last value between out_valid pulses.
REQ-027 SHALL use a group-framing FSM with states IDLE and OPEN: in_first&&in_last goes IDLE->IDLE and emits a result; in_first alone goes to OPEN; in_last in OPEN goes to IDLE.
REQ-028 SHALL handle a beat without in_first while IDLE as follows: discard the beat, pulse err, and stay IDLE.
REQ-029 SHALL handle in_first while OPEN as follows: pulse err, abandon the open group without output, and start a new group with this beat.
REQ-030 SHALL treat MAX_CH as a width bound only: exceeding it is not detected, and the result is then undefined.
REQ-031 SHALL assert out_sat only when clamping occurred; a RELU clamp alone SHALL NOT assert out_sat.

Reset
REQ-032 SHALL, while rst_n=0, asynchronously force out_data=0, out_valid=0, out_sat=0, err=0, FSM=IDLE, the accumulator to 0, and all pipeline valid flags to 0.
REQ-033 SHALL discard beats in flight at reset: no out_valid results from them after rst_n rises, and the first beat after reset SHALL be accepted normally.

Verification
REQ-034 SHALL be verified with: defaults, one beat with first=last=1, all wei=0x0100, ima=1, bias=0 -> out_data=0x3100 and out_valid exactly 9 cycles later, out_sat=0.
REQ-035 SHALL be verified with: a 3-beat group, all wei=0x0080, ima=1, bias=0x0100 -> a single out_valid, 9 cycles after the last beat, with out_data=0x4A80.
REQ-036 SHALL be verified with: all wei=0x7FFF, ima=255, bias=0x7FFF -> out_data=0x7FFF, out_sat=1; all wei=0x8000, ima=255 -> out_data=0x8000, out_sat=1.
REQ-037 SHALL be verified with: all wei=0xFF00, ima=1, bias=0 -> out_data=0xCF00 with RELU=0, and out_data=0x0000 with out_sat=0 with RELU=1.
REQ-038 SHALL be verified with: a non-first beat while IDLE -> err pulse and no output; first, first, last -> one err pulse and one result equal to the second group only.
REQ-039 SHALL be verified with: rst_n low for 2 cycles while 4 single-beat groups are in flight -> all outputs 0, no out_valid for those groups, and the next group correct with LAT=9.
